muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide sequencer in the Execute stage, alongside the ALU and branch unit.
- Accepts one M-extension op per start and runs a shift-add (multiply) or restoring (divide) datapath for 32 iterations.
- Holds the pipeline stalled while busy, then returns a registered result with a one-cycle done pulse.
- Divide-by-zero and signed overflow complete on a fast path.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- FAST_SPECIAL, 1, when 1 the div-by-zero and overflow cases complete in 1 cycle; when 0 they run the full iteration.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- startE  input  1  valid M-op in Execute; sampled only in IDLE.
- funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  input  WIDTH  rs1 operand (dividend / multiplicand).
- SrcBE  input  WIDTH  rs2 operand (divisor / multiplier).
- cancelE  input  1  flush of Execute; aborts the current op.
- stallE  output  1  combinational stall request to the hazard logic.
- busy  output  1  registered; high in CALC and FIXUP.
- done  output  1  registered; single-cycle completion pulse.
- result  output  WIDTH  registered result; held until the next completion.

Behaviour:
- States: IDLE, CALC, FIXUP, DONE.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, iteration counter=0, operand/accumulator registers=0.

IDLE:
- startE=1 and cancelE=0: latch funct3 and operands. Record the operand signs and store operand magnitudes.
  - Signed ops (MULH, DIV, REM) take both operands as signed.
  - MULHSU takes rs1 signed and rs2 unsigned.
  - Counter=0. Next state is CALC.
- Fast path (FAST_SPECIAL=1) goes straight to DONE when:
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- cancelE has priority over startE; the op is not accepted.

CALC:
- One iteration per cycle; counter increments; after iteration 31 (counter=31), next state is FIXUP.
- Multiply: 64-bit product accumulator on unsigned magnitudes.
- Divide: restoring shift-subtract producing a 32-bit quotient and remainder on magnitudes.

FIXUP (one cycle):
- Apply sign correction:
  - Product is negated if the operand signs differ (signed operands only).
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
- Select the result word:
  - MUL: low word of the product.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- result is loaded at the exit edge. Next state is DONE.

DONE (one cycle):
- done=1, busy=0, stallE=0; the pipeline advances and consumes result.
- Next state is IDLE unconditionally; startE is ignored in DONE.

stallE:
- stallE = (IDLE & startE & ~cancelE) | CALC | FIXUP.

Latency:
- Start accepted in cycle 0. done is high in cycle 34 (fast path: cycle 1).
- stallE is high for cycles 0–33 (fast path: cycle 0 only).

cancelE:
- In CALC/FIXUP: next state IDLE, no done pulse, result unchanged.
- In DONE: done still completes; the flush applies to the consumer.

General rules:
- result changes only on FIXUP exit or fast-path acceptance.
- All arithmetic is modulo 2^WIDTH; the internal product is 2·WIDTH bits wide.

Decomposition:
- Shared package muldiv_pkg holds:
  - Enum state_t {IDLE, CALC, FIXUP, DONE}.
  - funct3 localparams F3_MUL … F3_REMU.
  - Helper functions is_div(f3) and is_signed_a/b(f3).
- One combinational sub-module, muldiv_fixup: takes the sign flags, funct3, product, quotient and remainder, and returns the final result word. It is unit-testable in isolation.

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFFFFFD: stallE high cycles 0–33, done in cycle 34, result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero, fast path: DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with done in cycle 1 and stallE high only in cycle 0. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Abort: cancelE pulsed in CALC cycle 10 → IDLE next cycle, no done, result keeps its prior value. A new start after that completes normally.
- Reset: reset driven low asynchronously mid-CALC → busy/done/result=0 immediately. After release, back-to-back DIVU ops accept their second start in the cycle after DONE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types, funct3 encodings and operand-class helpers for the RV32M sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Sign correction and result-word selection applied to the magnitude datapath outputs.
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 neg_a_i,
    input  logic                 neg_b_i,
    input  logic                 div_zero_i,
    input  logic [2:0]           funct3_i,
    input  logic [2*WIDTH-1:0]   prod_i,
    input  logic [WIDTH-1:0]     quo_i,
    input  logic [WIDTH-1:0]     rem_i,
    output logic [WIDTH-1:0]     result_o
);

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    always_comb begin
        prod_s = (neg_a_i ^ neg_b_i) ? -prod_i : prod_i;
        // A zero divisor must leave the all-ones quotient intact.
        quo_s  = ((neg_a_i ^ neg_b_i) && !div_zero_i) ? -quo_i : quo_i;
        rem_s  = neg_a_i ? -rem_i : rem_i;
        result_o = '0;
        unique case (funct3_i)
            F3_MUL:                        result_o = prod_s[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result_o = prod_s[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:               result_o = quo_s;
            F3_REM, F3_REMU:               result_o = rem_s;
            default:                       result_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, 32 iterations,
// sign fixup cycle, then a one-cycle done pulse. Special divides may complete immediately.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [2:0]       funct3E,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             cancelE,
    output logic             stallE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_t               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [2:0]           f3_q;
    logic                 neg_a_q, neg_b_q, dz_q;
    logic [WIDTH-1:0]     op_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 busy_q, done_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     fix_res;

    logic                 neg_a, neg_b, div_zero, ovf, fast;
    logic [WIDTH-1:0]     a_mag, b_mag, fast_res;
    logic [WIDTH:0]       mul_sum, div_shift;

    always_comb begin
        neg_a    = is_signed_a(funct3E) & SrcAE[WIDTH-1];
        neg_b    = is_signed_b(funct3E) & SrcBE[WIDTH-1];
        a_mag    = neg_a ? -SrcAE : SrcAE;
        b_mag    = neg_b ? -SrcBE : SrcBE;
        div_zero = (SrcBE == '0);
        ovf      = ((funct3E == F3_DIV) || (funct3E == F3_REM))
                   && (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcBE == '1);
        fast     = FAST_SPECIAL && is_div(funct3E) && (div_zero || ovf);
        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) fast_res = funct3E[1] ? SrcAE : '1;
        else          fast_res = funct3E[1] ? '0 : SrcAE;
    end

    // Multiply: acc = {partial high, remaining multiplier}; divide: acc = {remainder, dividend}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        if (!is_div(f3_q)) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, op_q}) begin
            acc_d = {div_shift[WIDTH-1:0] - op_q, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    muldiv_fixup #(.WIDTH(WIDTH)) u_fixup (
        .neg_a_i    (neg_a_q),
        .neg_b_i    (neg_b_q),
        .div_zero_i (dz_q),
        .funct3_i   (f3_q),
        .prod_i     (acc_q),
        .quo_i      (acc_q[WIDTH-1:0]),
        .rem_i      (acc_q[2*WIDTH-1:WIDTH]),
        .result_o   (fix_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            op_q     <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (startE && !cancelE) begin
                        f3_q    <= funct3E;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        dz_q    <= div_zero;
                        cnt_q   <= '0;
                        if (fast) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            op_q    <= is_div(funct3E) ? b_mag : a_mag;
                            acc_q   <= {{WIDTH{1'b0}}, (is_div(funct3E) ? a_mag : b_mag)};
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cancelE) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        if (cnt_q == CntW'(WIDTH-1)) begin
                            cnt_q   <= '0;
                            state_q <= FIXUP;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                FIXUP: begin
                    busy_q <= 1'b0;
                    if (cancelE) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stallE = ((state_q == IDLE) && startE && !cancelE)
                    || (state_q == CALC) || (state_q == FIXUP);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed check of muldiv_unit against an arithmetic RV32M reference.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, startE, cancelE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE, SrcBE, result;
    logic        stallE, busy, done;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_result = '0;

    muldiv_unit #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .startE  (startE),
        .funct3E (funct3E),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .cancelE (cancelE),
        .stallE  (stallE),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_fast(input logic [2:0] f3, input logic [31:0] a, b);
        if (!f3[2]) return 1'b0;
        if (b == 32'h0) return 1'b1;
        return (f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'b001: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'b010: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
            3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Starts one op in the next cycle and follows it to completion with a cycle budget.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, b,
                          input logic [31:0] exp, input logic fast);
        int cyc, stalls, done_cyc;
        logic busy_at_done;
        @(posedge clk); #1;
        startE = 1'b1; funct3E = f3; SrcAE = a; SrcBE = b; cancelE = 1'b0;
        #1;
        stalls = stallE ? 1 : 0;
        done_cyc = -1;
        cyc = 0;
        busy_at_done = 1'b1;
        while (done_cyc < 0 && cyc < 60) begin
            @(posedge clk); #1;
            startE = 1'b0;
            cyc++;
            #1;
            if (stallE) stalls++;
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
        check_eq({tag, ":done_cycle"}, done_cyc, fast ? 32'd1 : 32'd34);
        check_eq({tag, ":stall_cycles"}, stalls, fast ? 32'd1 : 32'd34);
        check_eq({tag, ":busy_in_done"}, {31'h0, busy_at_done}, 32'h0);
        check_eq({tag, ":result"}, result, exp);
        last_result = exp;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          dones;

        reset = 1'b0; startE = 1'b0; cancelE = 1'b0; funct3E = '0; SrcAE = '0; SrcBE = '0;
        #12;
        check_eq("reset:busy", {31'h0, busy}, 32'h0);
        check_eq("reset:done", {31'h0, done}, 32'h0);
        check_eq("reset:result", result, 32'h0);
        check_eq("reset:stall", {31'h0, stallE}, 32'h0);
        reset = 1'b1;

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        run_op("div_neg0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("rem_neg0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), f3, a, b, ref_result(f3, a, b), ref_fast(f3, a, b));
        end

        // Abort: start a multiply, flush it in CALC cycle 10.
        run_op("pre_cancel", 3'b101, 32'd1000, 32'd3, 32'd333, 1'b0);
        @(posedge clk); #1;
        startE = 1'b1; funct3E = 3'b000; SrcAE = 32'd12345; SrcBE = 32'd678;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            startE = 1'b0;
        end
        cancelE = 1'b1;
        @(posedge clk); #1;
        cancelE = 1'b0;
        #1;
        check_eq("cancel:busy", {31'h0, busy}, 32'h0);
        check_eq("cancel:stall", {31'h0, stallE}, 32'h0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check_eq("cancel:no_done", dones, 32'd0);
        check_eq("cancel:result_kept", result, last_result);
        run_op("post_cancel", 3'b000, 32'd12345, 32'd678, 32'd8369910, 1'b0);

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #1;
        startE = 1'b1; funct3E = 3'b101; SrcAE = 32'd77; SrcBE = 32'd5;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            startE = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        check_eq("areset:busy", {31'h0, busy}, 32'h0);
        check_eq("areset:done", {31'h0, done}, 32'h0);
        check_eq("areset:result", result, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op("b2b_1", 3'b101, 32'd77, 32'd5, 32'd15, 1'b0);
        run_op("b2b_2", 3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
